// File: rtl/chunk_loader.sv
// chunk_loader: collects a 1..MAXLEN byte message, pads it into a single
// 512-bit MD5 chunk (16 little-endian words), starts the cruncher and holds
// the chunk stable on the gaddr/mdata read port until the cruncher is done.
module chunk_loader #(
    // Longest accepted message; must stay <= 55 so data, 0x80 and length fit.
    parameter int MAXLEN = 55
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        in_ready,
    input  logic [3:0]  gaddr,
    output logic [31:0] mdata,
    output logic        crunch_start,
    input  logic        crunch_done,
    output logic        msg_done,
    output logic        len_err,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_LOAD  = 3'd0,
        S_PAD   = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    localparam logic [5:0] MAX_CNT = 6'(MAXLEN);

    // Replace one byte lane of a word (lane 0 = bits [7:0], MD5 little-endian).
    function automatic logic [31:0] put_byte(input logic [31:0] word,
                                             input logic [1:0]  lane,
                                             input logic [7:0]  data);
        logic [31:0] res;
        res = word;
        case (lane)
            2'd0:    res[7:0]   = data;
            2'd1:    res[15:8]  = data;
            2'd2:    res[23:16] = data;
            2'd3:    res[31:24] = data;
            default: res        = word;
        endcase
        return res;
    endfunction

    state_t      state_r;
    state_t      state_s;
    logic [31:0] w_r [16];
    logic [5:0]  cnt_r;
    logic        wait_first_r;

    logic        accept_s;
    logic        load_wr_s;
    logic        to_load_s;
    logic        msg_done_s;
    logic        len_err_s;

    logic        in_ready_r;
    logic        busy_r;
    logic        crunch_start_r;
    logic        msg_done_r;
    logic        len_err_r;

    assign in_ready     = in_ready_r;
    assign busy         = busy_r;
    assign crunch_start = crunch_start_r;
    assign msg_done     = msg_done_r;
    assign len_err      = len_err_r;

    // Read port: the cruncher sees the addressed word with no added latency.
    assign mdata = w_r[gaddr];

    // Next-state decode, byte-accept qualification and event pulses.
    always_comb begin
        state_s    = state_r;
        accept_s   = 1'b0;
        load_wr_s  = 1'b0;
        to_load_s  = 1'b0;
        msg_done_s = 1'b0;
        len_err_s  = 1'b0;
        case (state_r)
            S_LOAD: begin
                accept_s = in_valid;
                if (in_valid) begin
                    if (cnt_r == MAX_CNT) begin
                        // No room for another byte: drop the message. If this
                        // byte already ends it there is nothing left to drain.
                        len_err_s = 1'b1;
                        if (in_last) begin
                            state_s   = S_LOAD;
                            to_load_s = 1'b1;
                        end else begin
                            state_s   = S_DRAIN;
                        end
                    end else begin
                        load_wr_s = 1'b1;
                        if (in_last) begin
                            state_s = S_PAD;
                        end else begin
                            state_s = S_LOAD;
                        end
                    end
                end else begin
                    state_s = S_LOAD;
                end
            end
            S_PAD: begin
                state_s = S_START;
            end
            S_START: begin
                state_s = S_WAIT;
            end
            S_WAIT: begin
                // The done level may still be high from the previous chunk
                // on the first WAIT cycle, so it is only trusted afterwards.
                if (!wait_first_r && crunch_done) begin
                    msg_done_s = 1'b1;
                    to_load_s  = 1'b1;
                    state_s    = S_LOAD;
                end else begin
                    state_s    = S_WAIT;
                end
            end
            S_DRAIN: begin
                accept_s = in_valid;
                if (in_valid && in_last) begin
                    to_load_s = 1'b1;
                    state_s   = S_LOAD;
                end else begin
                    state_s   = S_DRAIN;
                end
            end
            default: begin
                to_load_s = 1'b1;
                state_s   = S_LOAD;
            end
        endcase
    end

    // State register, byte counter and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= S_LOAD;
            cnt_r          <= 6'd0;
            wait_first_r   <= 1'b0;
            in_ready_r     <= 1'b1;
            busy_r         <= 1'b0;
            crunch_start_r <= 1'b0;
            msg_done_r     <= 1'b0;
            len_err_r      <= 1'b0;
        end else begin
            state_r        <= state_s;
            wait_first_r   <= (state_r == S_START);
            in_ready_r     <= (state_s == S_LOAD) || (state_s == S_DRAIN);
            busy_r         <= (state_s != S_LOAD);
            crunch_start_r <= (state_s == S_START);
            msg_done_r     <= msg_done_s;
            len_err_r      <= len_err_s;
            if (to_load_s) begin
                cnt_r <= 6'd0;
            end else if (load_wr_s && accept_s) begin
                // After the last byte cnt_r holds the message length L.
                cnt_r <= cnt_r + 6'd1;
            end
        end
    end

    // Chunk word storage: cleared on LOAD entry, filled in LOAD, padded in PAD.
    always_ff @(posedge clk) begin
        if (reset || to_load_s) begin
            for (int i = 0; i < 16; i++) begin
                w_r[i] <= 32'd0;
            end
        end else if (load_wr_s) begin
            w_r[cnt_r[5:2]] <= put_byte(w_r[cnt_r[5:2]], cnt_r[1:0], in_data);
        end else if (state_r == S_PAD) begin
            // cnt_r <= 55 here, so the 0x80 marker never lands in word 14.
            w_r[cnt_r[5:2]] <= put_byte(w_r[cnt_r[5:2]], cnt_r[1:0], 8'h80);
            w_r[14]         <= {23'd0, cnt_r, 3'b000};
        end
    end

endmodule

// File: tb/tb_chunk_loader.sv
// Directed bench for chunk_loader: a padding model pushes expected chunk words
// to a scoreboard queue; they are popped when the loader issues crunch_start.
module tb_chunk_loader;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;
    logic        in_ready;
    logic [3:0]  gaddr;
    logic [31:0] mdata;
    logic        crunch_start;
    logic        crunch_done;
    logic        msg_done;
    logic        len_err;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int start_cnt = 0;
    int done_cnt  = 0;
    int lerr_cnt  = 0;

    logic [31:0] exp_q[$];
    logic [7:0]  msg[$];

    chunk_loader #(.MAXLEN(55)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .gaddr        (gaddr),
        .mdata        (mdata),
        .crunch_start (crunch_start),
        .crunch_done  (crunch_done),
        .msg_done     (msg_done),
        .len_err      (len_err),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    // Count output pulses independently of the directed checks.
    always @(negedge clk) begin
        if (crunch_start === 1'b1) start_cnt++;
        if (msg_done === 1'b1) done_cnt++;
        if (len_err === 1'b1) lerr_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Standard MD5 padding of a short message into 16 little-endian words.
    task automatic push_model(input logic [7:0] m[$]);
        logic [7:0]  b [64];
        logic [63:0] bits;
        for (int i = 0; i < 64; i++) b[i] = 8'h00;
        for (int i = 0; i < m.size(); i++) b[i] = m[i];
        b[m.size()] = 8'h80;
        bits = 64'(m.size()) * 64'd8;
        for (int i = 0; i < 8; i++) b[56 + i] = bits[8*i +: 8];
        for (int i = 0; i < 16; i++) exp_q.push_back({b[4*i+3], b[4*i+2], b[4*i+1], b[4*i]});
    endtask

    task automatic push_zeros();
        for (int i = 0; i < 16; i++) exp_q.push_back(32'd0);
    endtask

    // Sweep the read port and compare against the scoreboard (16 x 1 ns).
    task automatic check_words(input string tag);
        logic [31:0] e;
        for (int i = 0; i < 16; i++) begin
            gaddr = 4'(i);
            #1;
            if (exp_q.size() == 0) begin
                chk({tag, "_sb_empty"}, 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("%s_w%0d", tag, i), mdata, e);
            end
        end
        gaddr = 4'd0;
    endtask

    // Offer bytes one per cycle; starts and ends 1 ns after a rising edge.
    task automatic send(input logic [7:0] m[$]);
        for (int i = 0; i < m.size(); i++) begin
            in_valid = 1'b1;
            in_data  = m[i];
            in_last  = (i == m.size() - 1);
            @(negedge clk);
            chk("in_ready_load", in_ready, 32'd1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'h00;
    endtask

    // Full message: load, PAD, START (word check), WAIT with done, back to LOAD.
    task automatic run_msg(input string tag, input logic [7:0] m[$]);
        push_model(m);
        send(m);
        @(negedge clk);
        chk({tag, "_pad_ready"}, in_ready, 32'd0);
        chk({tag, "_pad_busy"}, busy, 32'd1);
        chk({tag, "_pad_start"}, crunch_start, 32'd0);
        @(negedge clk);
        chk({tag, "_start"}, crunch_start, 32'd1);
        chk({tag, "_start_ready"}, in_ready, 32'd0);
        check_words(tag);
        crunch_done = 1'b1;
        @(negedge clk);
        chk({tag, "_wait1_start"}, crunch_start, 32'd0);
        chk({tag, "_wait1_done"}, msg_done, 32'd0);
        chk({tag, "_wait1_ready"}, in_ready, 32'd0);
        @(negedge clk);
        chk({tag, "_wait2_done"}, msg_done, 32'd0);
        chk({tag, "_wait2_busy"}, busy, 32'd1);
        chk({tag, "_wait2_ready"}, in_ready, 32'd0);
        @(negedge clk);
        crunch_done = 1'b0;
        chk({tag, "_msg_done"}, msg_done, 32'd1);
        chk({tag, "_load_busy"}, busy, 32'd0);
        chk({tag, "_load_ready"}, in_ready, 32'd1);
        chk({tag, "_cleared_w0"}, mdata, 32'd0);
        @(negedge clk);
        chk({tag, "_msg_done_low"}, msg_done, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_data     = 8'h00;
        in_last     = 1'b0;
        gaddr       = 4'd0;
        crunch_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state.
        @(negedge clk);
        chk("rst_in_ready", in_ready, 32'd1);
        chk("rst_busy", busy, 32'd0);
        chk("rst_start", crunch_start, 32'd0);
        chk("rst_msg_done", msg_done, 32'd0);
        chk("rst_len_err", len_err, 32'd0);
        push_zeros();
        check_words("rst");
        @(posedge clk);
        #1;

        // "abc", "abcd", then back-to-back "abc" and "a".
        msg = '{8'h61, 8'h62, 8'h63};
        run_msg("abc", msg);
        msg = '{8'h61, 8'h62, 8'h63, 8'h64};
        run_msg("abcd", msg);
        msg = '{8'h61, 8'h62, 8'h63};
        run_msg("abc2", msg);
        msg = '{8'h61};
        run_msg("a", msg);

        // Longest message: 55 x 'a'.
        msg.delete();
        for (int i = 0; i < 55; i++) msg.push_back(8'h61);
        run_msg("a55", msg);

        // 60-byte message: dropped on byte 56, rest drained.
        for (int i = 0; i < 60; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            in_last  = (i == 59);
            @(negedge clk);
            chk("ovf_ready", in_ready, 32'd1);
            if (i == 56) begin
                chk("ovf_len_err", len_err, 32'd1);
                chk("ovf_drain_busy", busy, 32'd1);
            end
            if (i == 57) chk("ovf_len_err_low", len_err, 32'd0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        chk("ovf_back_busy", busy, 32'd0);
        chk("ovf_back_start", crunch_start, 32'd0);
        push_zeros();
        check_words("ovf");
        @(posedge clk);
        #1;

        // in_last without in_valid does nothing.
        in_last = 1'b1;
        @(posedge clk);
        #1;
        in_last = 1'b0;
        @(negedge clk);
        chk("lastnovalid_busy", busy, 32'd0);

        // Reset asserted while in WAIT.
        @(posedge clk);
        #1;
        msg = '{8'h61, 8'h62};
        send(msg);
        @(negedge clk);
        @(negedge clk);
        chk("rstw_start", crunch_start, 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rstw_busy", busy, 32'd0);
        chk("rstw_ready", in_ready, 32'd1);
        chk("rstw_start_low", crunch_start, 32'd0);
        chk("rstw_msg_done", msg_done, 32'd0);
        push_zeros();
        check_words("rstw");
        repeat (3) @(negedge clk);

        // Pulse totals: six starts, five completions, one length error.
        chk("total_starts", 32'(start_cnt), 32'd6);
        chk("total_msg_done", 32'(done_cnt), 32'd5);
        chk("total_len_err", 32'(lerr_cnt), 32'd1);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
